// File: rtl/st2bus_pkg.sv
// Shared defaults and types for the Avalon-ST to bus-word packer.
package st2bus_pkg;
  localparam int ST_DEF    = 8;
  localparam int BUS_W_DEF = 512;
  localparam int NST_DEF   = BUS_W_DEF / ST_DEF;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_IN_PKT = 1'b1
  } state_e;

  // FIFO entry at default geometry; the top builds the same shape from its parameters
  typedef struct packed {
    logic [BUS_W_DEF-1:0]          data;
    logic                          last;
    logic [$clog2(NST_DEF+1)-1:0]  nst;
  } entry_t;
endpackage

// File: rtl/st2bus_fifo.sv
// Synchronous FIFO of packed bus words; caller guarantees no push into a full
// FIFO unless a pop happens in the same cycle, and no pop when empty.
module st2bus_fifo
  import st2bus_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = entry_t,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH+1)
)(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  T              wdata_i,
  input  logic          pop_i,
  output T              rdata_o,
  output logic [CW-1:0] count_o
);
  T                mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q;

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

  // pointer and occupancy tracking; push+pop together leaves occupancy unchanged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      if (push_i && !pop_i)      cnt_q <= cnt_q + CW'(1);
      else if (pop_i && !push_i) cnt_q <= cnt_q - CW'(1);
    end
  end

  // storage needs no reset: nothing is read before it is written
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/st2bus_pack.sv
// Packs Avalon-ST symbols LSB-first into wide bus words, buffers them in a
// small FIFO and presents them through a registered output stage.
module st2bus_pack
  import st2bus_pkg::*;
#(
  parameter int  ST    = ST_DEF,
  parameter int  BUS_W = BUS_W_DEF,
  parameter int  DEPTH = 4,
  localparam int NST   = BUS_W / ST,
  localparam int NSTW  = $clog2(NST+1),
  localparam int CW    = $clog2(DEPTH+1)
)(
  input  logic             clk_bus,
  input  logic             rst_n,
  input  logic [ST-1:0]    st_data,
  input  logic             st_valid,
  input  logic             st_sop,
  input  logic             st_eop,
  output logic             st_ready,
  input  logic             bus_ready,
  output logic [BUS_W-1:0] bus_data,
  output logic             bus_en,
  output logic             bus_last,
  output logic [NSTW-1:0]  bus_nst,
  output logic             pkt_err,
  output logic [15:0]      drop_cnt
);
  typedef struct packed {
    logic [BUS_W-1:0] data;
    logic             last;
    logic [NSTW-1:0]  nst;
  } word_t;

  state_e           state_q, state_d;
  logic [NSTW-1:0]  lane_q, lane_d;
  logic [BUS_W-1:0] asm_q, asm_d;
  logic             flush_q, flush_d;   // asm holds a finished word waiting for the write port
  logic             flast_q, flast_d;
  logic             st_ready_q, st_ready_d;
  logic             pkt_err_q, err_d;
  logic [15:0]      drop_q, drop_d;
  logic             bus_en_q, bus_last_q;
  logic [BUS_W-1:0] bus_data_q;
  logic [NSTW-1:0]  bus_nst_q;

  logic             acc, push, pop;
  word_t            push_w, head;
  logic [CW-1:0]    fifo_cnt;
  logic [BUS_W-1:0] word;
  logic [NSTW-1:0]  pos;
  int               cnt_nxt;

  assign acc = st_valid & st_ready_q;
  assign pop = bus_ready & (fifo_cnt != '0);

  st2bus_fifo #(.DEPTH(DEPTH), .T(word_t)) u_fifo (
    .clk_i   (clk_bus),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (push_w),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_cnt)
  );

  // packer: place accepted symbol, decide commits, track packet state and errors
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    flush_d = flush_q;
    flast_d = flast_q;
    err_d   = 1'b0;
    drop_d  = drop_q;
    push    = 1'b0;
    push_w  = '0;
    word    = '0;
    pos     = '0;
    if (flush_q) begin
      if (fifo_cnt < CW'(DEPTH) || pop) begin
        push        = 1'b1;
        push_w.data = asm_q;
        push_w.last = flast_q;
        push_w.nst  = lane_q;
        asm_d       = '0;
        lane_d      = '0;
        flush_d     = 1'b0;
      end
    end else if (acc) begin
      if (!st_sop && state_q == S_IDLE) begin
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end else begin
        if (st_sop) begin
          // restart at lane 0; a sop inside a packet closes the pending partial word
          if (state_q == S_IN_PKT) begin
            err_d = 1'b1;
            if (lane_q != '0) begin
              push        = 1'b1;
              push_w.data = asm_q;
              push_w.last = 1'b1;
              push_w.nst  = lane_q;
            end
          end
        end else begin
          word = asm_q;
          pos  = lane_q;
        end
        word[int'(pos)*ST +: ST] = st_data;
        state_d = st_eop ? S_IDLE : S_IN_PKT;
        if (st_eop || pos == NSTW'(NST-1)) begin
          if (push) begin
            // write port already taken by the closed partial word: commit next cycle
            asm_d   = word;
            lane_d  = pos + NSTW'(1);
            flast_d = st_eop;
            flush_d = 1'b1;
          end else begin
            push        = 1'b1;
            push_w.data = word;
            push_w.last = st_eop;
            push_w.nst  = pos + NSTW'(1);
            asm_d       = '0;
            lane_d      = '0;
          end
        end else begin
          asm_d  = word;
          lane_d = pos + NSTW'(1);
        end
      end
    end
    cnt_nxt    = int'(fifo_cnt) + int'(push) - int'(pop);
    st_ready_d = (cnt_nxt < DEPTH) && !flush_d;
  end

  // packer state registers; st_ready registered so it has no path from bus_ready
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lane_q     <= '0;
      asm_q      <= '0;
      flush_q    <= 1'b0;
      flast_q    <= 1'b0;
      st_ready_q <= 1'b0;
      pkt_err_q  <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      asm_q      <= asm_d;
      flush_q    <= flush_d;
      flast_q    <= flast_d;
      st_ready_q <= st_ready_d;
      pkt_err_q  <= err_d;
      drop_q     <= drop_d;
    end
  end

  // output stage: pop into registers, bus_en pulses one cycle, payload holds
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      bus_en_q   <= 1'b0;
      bus_data_q <= '0;
      bus_last_q <= 1'b0;
      bus_nst_q  <= '0;
    end else begin
      bus_en_q <= pop;
      if (pop) begin
        bus_data_q <= head.data;
        bus_last_q <= head.last;
        bus_nst_q  <= head.nst;
      end
    end
  end

  assign st_ready = st_ready_q;
  assign pkt_err  = pkt_err_q;
  assign drop_cnt = drop_q;
  assign bus_en   = bus_en_q;
  assign bus_data = bus_data_q;
  assign bus_last = bus_last_q;
  assign bus_nst  = bus_nst_q;
endmodule

// File: tb/tb_st2bus_pack.sv
// Directed + randomized bench for st2bus_pack; expected words come from a
// symbol-queue packet model, compared in order as words leave the bus.
module tb_st2bus_pack;
  localparam int NST = 64;

  logic         clk_bus = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   st_data = '0;
  logic         st_valid = 1'b0, st_sop = 1'b0, st_eop = 1'b0;
  logic         st_ready;
  logic         bus_ready = 1'b0;
  logic [511:0] bus_data;
  logic         bus_en, bus_last;
  logic [6:0]   bus_nst;
  logic         pkt_err;
  logic [15:0]  drop_cnt;

  st2bus_pack dut (
    .clk_bus(clk_bus), .rst_n(rst_n), .st_data(st_data), .st_valid(st_valid),
    .st_sop(st_sop), .st_eop(st_eop), .st_ready(st_ready), .bus_ready(bus_ready),
    .bus_data(bus_data), .bus_en(bus_en), .bus_last(bus_last), .bus_nst(bus_nst),
    .pkt_err(pkt_err), .drop_cnt(drop_cnt)
  );

  always #5 clk_bus = ~clk_bus;

  typedef struct {
    logic [511:0] d;
    logic         l;
    int           n;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] cur[$];
  bit         in_pkt = 0;
  bit         m_err = 0;
  int         m_drop = 0;
  bit         acc = 0;
  bit         rand_br = 0;
  int         words = 0, errs_seen = 0;
  int         errors = 0, checks = 0;

  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void emit(logic last);
    exp_t e;
    e.d = '0;
    for (int i = 0; i < cur.size(); i++) e.d[i*8 +: 8] = cur[i];
    e.l = last;
    e.n = cur.size();
    exp_q.push_back(e);
    cur.delete();
  endfunction

  // packet-level rules applied to one accepted symbol
  function automatic void model_accept(logic [7:0] d, logic sop, logic eop);
    if (!sop && !in_pkt) begin
      if (m_drop != 16'hFFFF) m_drop++;
      return;
    end
    if (sop && in_pkt) begin
      m_err = 1;
      if (cur.size() > 0) emit(1'b1);
    end
    if (sop) cur.delete();
    cur.push_back(d);
    if (eop) begin
      emit(1'b1);
      in_pkt = 0;
    end else begin
      in_pkt = 1;
      if (cur.size() == NST) emit(1'b0);
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    cur.delete();
    in_pkt = 0;
    m_drop = 0;
  endfunction

  task automatic cycle();
    exp_t e;
    if (rand_br) bus_ready = ($urandom_range(0, 3) != 0);
    m_err = 0;
    acc = 0;
    if (rst_n && st_valid && st_ready) begin
      acc = 1;
      model_accept(st_data, st_sop, st_eop);
    end
    @(posedge clk_bus); #1;
    chk("pkt_err", 512'(pkt_err), 512'(m_err));
    chk("drop_cnt", 512'(drop_cnt), 512'(m_drop));
    if (pkt_err) errs_seen++;
    if (bus_en) begin
      words++;
      chk("bus_en_expected", 512'(bus_en), 512'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("bus_data", bus_data, e.d);
        chk("bus_last", 512'(bus_last), 512'(e.l));
        chk("bus_nst", 512'(bus_nst), 512'(e.n));
      end
    end
  endtask

  task automatic send(logic [7:0] d, logic sop, logic eop);
    st_data = d; st_sop = sop; st_eop = eop; st_valid = 1'b1;
    acc = 0;
    for (int n = 0; n < 200 && !acc; n++) cycle();
    if (!acc) chk("send_timeout", 512'(acc), 512'(1));
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    rand_br = 0;
    bus_ready = 1'b1;
    for (int n = 0; n < 80 && exp_q.size() != 0; n++) cycle();
    idle(3);
    chk("drain_empty", 512'(exp_q.size()), 512'(0));
  endtask

  task automatic packet(int len, int base);
    for (int i = 0; i < len; i++) send(8'(base + i), i == 0, i == len - 1);
  endtask

  initial begin
    int w0, e0, len;
    logic s, e;

    // reset state
    repeat (2) @(posedge clk_bus);
    #1;
    chk("rst_st_ready", 512'(st_ready), 512'(0));
    chk("rst_bus_en", 512'(bus_en), 512'(0));
    chk("rst_bus_data", bus_data, 512'(0));
    chk("rst_bus_nst", 512'(bus_nst), 512'(0));
    chk("rst_drop_cnt", 512'(drop_cnt), 512'(0));
    rst_n = 1'b1;
    cycle();
    chk("st_ready_after_rst", 512'(st_ready), 512'(1));

    // two full words from a 128-symbol packet
    bus_ready = 1'b1;
    w0 = words;
    packet(128, 0);
    drain();
    chk("pkt128_words", 512'(words - w0), 512'(2));

    // 70-symbol packet: trailing 6-lane word
    w0 = words;
    packet(70, 8'h30);
    drain();
    chk("pkt70_words", 512'(words - w0), 512'(2));

    // backpressure: FIFO fills at 256 symbols
    bus_ready = 1'b0;
    w0 = words;
    for (int i = 0; i < 256; i++) send(8'(i * 3), i == 0, 1'b0);
    st_data = 8'(256 * 3); st_valid = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    chk("st_ready_full", 512'(st_ready), 512'(0));
    chk("held_no_words", 512'(words - w0), 512'(0));
    bus_ready = 1'b1;
    for (int i = 256; i < 320; i++) send(8'(i * 3), 1'b0, i == 319);
    drain();
    chk("bp_words", 512'(words - w0), 512'(5));

    // sop at symbol 10 of a running packet
    e0 = errs_seen; w0 = words;
    for (int i = 0; i < 15; i++) send(8'(8'h80 + i), i == 0 || i == 10, i == 14);
    drain();
    chk("sop_mid_err", 512'(errs_seen - e0), 512'(1));
    chk("sop_mid_words", 512'(words - w0), 512'(2));

    // sop&eop inside a packet with a pending partial word
    w0 = words;
    for (int i = 0; i < 3; i++) send(8'(8'h10 + i), i == 0, 1'b0);
    send(8'h77, 1'b1, 1'b1);
    drain();
    chk("sop_eop_mid_words", 512'(words - w0), 512'(2));

    // drops in IDLE, then a one-symbol packet
    w0 = words;
    for (int i = 0; i < 5; i++) send(8'(8'hC0 + i), 1'b0, 1'b0);
    chk("drop_cnt_5", 512'(drop_cnt), 512'(5));
    send(8'hA5, 1'b1, 1'b1);
    drain();
    chk("single_words", 512'(words - w0), 512'(1));

    // randomized traffic with random backpressure
    rand_br = 1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 150);
      if ($urandom_range(0, 4) == 0) send(8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < len; i++) begin
        s = (i == 0) || ($urandom_range(0, 50) == 0);
        e = (i == len - 1) || (s && i != 0 && $urandom_range(0, 1) == 0);
        send(8'($urandom), s, e);
        if ($urandom_range(0, 7) == 0) idle(1);
      end
    end
    drain();

    // asynchronous reset mid-packet with a word stuck in the FIFO
    bus_ready = 1'b0;
    packet(64, 8'h40);
    for (int i = 0; i < 30; i++) send(8'(i), i == 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_st_ready", 512'(st_ready), 512'(0));
    chk("arst_bus_en", 512'(bus_en), 512'(0));
    chk("arst_bus_last", 512'(bus_last), 512'(0));
    chk("arst_bus_nst", 512'(bus_nst), 512'(0));
    chk("arst_bus_data", bus_data, 512'(0));
    chk("arst_pkt_err", 512'(pkt_err), 512'(0));
    chk("arst_drop_cnt", 512'(drop_cnt), 512'(0));
    model_reset();
    @(posedge clk_bus); #1;
    rst_n = 1'b1;
    bus_ready = 1'b1;
    cycle();
    chk("st_ready_rerise", 512'(st_ready), 512'(1));
    w0 = words;
    packet(64, 8'h90);
    drain();
    chk("post_rst_words", 512'(words - w0), 512'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
